// File: rtl/osc_freq_counter.sv
// Ring-oscillator frequency counter with a Wishbone slave register interface.
// Each channel counts synchronised rising edges over a programmable gate window.
// At the end of the window the live counts are latched into COUNT registers.
module osc_freq_counter #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned CNT_W  = 24,
    parameter int unsigned GATE_W = 24
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [NCH-1:0]    osc_in,
    output logic [NCH-1:0]    osc_en,
    output logic              irq
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GATE  = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    localparam logic [3:0]  A_CTRL     = 4'd0;
    localparam logic [3:0]  A_GATE     = 4'd1;
    localparam logic [3:0]  A_STATUS   = 4'd2;
    localparam int unsigned COUNT_BASE = 4;

    // Bus side
    logic              r_ack;
    logic [31:0]       r_dat_o;
    logic [3:0]        w_adr;
    logic              w_acc;
    logic              w_wr;
    logic              w_wr_ctrl;
    logic              w_wr_gate;
    logic              w_wr_status;
    logic              w_start;
    logic              w_abort;
    logic [31:0]       w_rd_data;

    // Control / status registers
    logic [NCH-1:0]    r_osc_en;
    logic              r_cont;
    logic              r_irq_en;
    logic [GATE_W-1:0] r_gate;
    logic              r_done;
    logic [NCH-1:0]    r_ovf;
    logic              r_irq;
    logic              w_done_nxt;
    logic              w_irq_en_nxt;
    logic [NCH-1:0]    w_ovf_nxt;

    // Sequencer
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_load;
    logic              w_latch;
    logic              w_busy;
    logic [GATE_W-1:0] r_gate_cnt;

    // Edge detection and counting
    logic [NCH-1:0]    r_sync1;
    logic [NCH-1:0]    r_sync2;
    logic [NCH-1:0]    r_sync3;
    logic [NCH-1:0]    w_pulse;
    logic [CNT_W-1:0]  r_live  [NCH];
    logic [NCH-1:0]    r_live_ovf;
    logic [CNT_W-1:0]  r_count [NCH];

    logic              w_unused;

    assign w_adr       = wbs_adr_i[5:2];
    assign w_acc       = wbs_cyc_i & wbs_stb_i & ~r_ack;
    assign w_wr        = w_acc & wbs_we_i;
    assign w_wr_ctrl   = w_wr & (w_adr == A_CTRL);
    assign w_wr_gate   = w_wr & (w_adr == A_GATE);
    assign w_wr_status = w_wr & (w_adr == A_STATUS);
    assign w_start     = w_wr_ctrl & wbs_dat_i[16];
    assign w_abort     = w_wr_status & wbs_dat_i[16];
    assign w_busy      = (r_state != S_IDLE);
    assign w_latch     = (r_state == S_LATCH) & ~w_abort;
    assign w_pulse     = r_sync2 & ~r_sync3;

    // Byte selects and undecoded address/data bits carry no meaning here
    assign w_unused = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i};

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat_o;
    assign osc_en    = r_osc_en;
    assign irq       = r_irq;

    // Read mux: values as they stand before the accepting edge
    always_comb begin
        w_rd_data = '0;
        case (w_adr)
            A_CTRL: begin
                w_rd_data[NCH-1:0] = r_osc_en;
                w_rd_data[17]      = r_cont;
                w_rd_data[18]      = r_irq_en;
            end
            A_GATE: begin
                w_rd_data = 32'(r_gate);
            end
            A_STATUS: begin
                w_rd_data[0]       = w_busy;
                w_rd_data[1]       = r_done;
                w_rd_data[8 +: NCH] = r_ovf;
            end
            default: begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (w_adr == 4'(COUNT_BASE + i)) begin
                        w_rd_data = 32'(r_count[i]);
                    end
                end
            end
        endcase
    end

    // Single-cycle ack with registered read data
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack   <= 1'b0;
            r_dat_o <= '0;
        end else begin
            r_ack <= w_acc;
            if (w_acc) begin
                r_dat_o <= w_rd_data;
            end
        end
    end

    // Next values for flags that also feed the registered interrupt
    always_comb begin
        w_irq_en_nxt = w_wr_ctrl ? wbs_dat_i[18] : r_irq_en;
        if (w_latch) begin
            w_done_nxt = 1'b1;
        end else if (w_wr_status && wbs_dat_i[1]) begin
            w_done_nxt = 1'b0;
        end else begin
            w_done_nxt = r_done;
        end
        w_ovf_nxt = w_wr_status ? (r_ovf & ~wbs_dat_i[8 +: NCH]) : r_ovf;
        if (w_latch) begin
            w_ovf_nxt = w_ovf_nxt | r_live_ovf;
        end
    end

    // Control, gate and status registers; latch sets win over clears
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_osc_en <= '0;
            r_cont   <= 1'b0;
            r_irq_en <= 1'b0;
            r_gate   <= '0;
            r_done   <= 1'b0;
            r_ovf    <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_osc_en <= wbs_dat_i[NCH-1:0];
                r_cont   <= wbs_dat_i[17];
                r_irq_en <= wbs_dat_i[18];
            end
            if (w_wr_gate) begin
                r_gate <= wbs_dat_i[GATE_W-1:0];
            end
            r_done <= w_done_nxt;
            r_ovf  <= w_ovf_nxt;
            r_irq  <= w_done_nxt & w_irq_en_nxt;
        end
    end

    // Sequencer state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next state; abort beats everything, start needs a nonzero gate
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start && !w_abort && (r_gate != '0)) begin
                    w_state_nxt = S_GATE;
                    w_load      = 1'b1;
                end
            end
            S_GATE: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_gate_cnt == GATE_W'(1)) begin
                    w_state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cont) begin
                    w_state_nxt = S_GATE;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Gate window down-counter
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_gate_cnt <= '0;
        end else if (w_load) begin
            r_gate_cnt <= r_gate;
        end else if ((r_state == S_GATE) && (r_gate_cnt != '0)) begin
            r_gate_cnt <= r_gate_cnt - GATE_W'(1);
        end
    end

    // Two-flop synchroniser plus one flop for rising-edge detection
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= osc_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Saturating live edge counters, active only during the gate window
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || w_load) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                r_live[i] <= '0;
            end
            r_live_ovf <= '0;
        end else if (r_state == S_GATE) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (r_osc_en[i] && w_pulse[i]) begin
                    if (r_live[i] == '1) begin
                        r_live_ovf[i] <= 1'b1;
                    end else begin
                        r_live[i] <= r_live[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Latched result registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                r_count[i] <= '0;
            end
        end else if (w_latch) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                r_count[i] <= r_live[i];
            end
        end
    end

endmodule

// File: tb/tb_osc_freq_counter.sv
// Testbench for osc_freq_counter: two instances (24-bit and 4-bit counters)
// share one bus and oscillator set; a transaction-level model predicts every
// bus response, osc_en and irq each cycle, and directed scenarios add literals.
module tb_osc_freq_counter;

    localparam int unsigned NCH   = 4;
    localparam int unsigned MAX_A = 32'h00FF_FFFF;
    localparam int unsigned MAX_B = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              cyc, stb, we;
    logic [3:0]        sel;
    logic [31:0]       adr, dat;
    logic              ack_a, ack_b, irq_a, irq_b;
    logic [31:0]       dat_a, dat_b;
    logic [NCH-1:0]    en_a, en_b;
    logic [NCH-1:0]    osc_r = '0;

    int                vectors = 0;
    int                miscompares = 0;
    int                cyc_cnt = 0;
    int                half [NCH];
    int                ocnt [NCH];

    // Reference model state
    bit                m_valid = 1'b0;
    bit                m_ack, m_busy, m_done, m_cont, m_irqen;
    logic [31:0]       m_dat_a, m_dat_b, m_gate;
    logic [NCH-1:0]    m_en, m_ovf_a, m_ovf_b, m_h1, m_h2, m_h3;
    int unsigned       m_rem;
    int unsigned       m_live [NCH];
    int unsigned       m_cnt  [NCH];
    logic              t_acc, t_wr, t_start, t_abort, t_latch;
    logic [3:0]        t_idx;
    logic [NCH-1:0]    t_pulse, t_set_a, t_set_b;

    osc_freq_counter u_dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(ack_a), .wbs_dat_o(dat_a), .osc_in(osc_r), .osc_en(en_a),
        .irq(irq_a)
    );

    osc_freq_counter #(.CNT_W(4)) u_dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(ack_b), .wbs_dat_o(dat_b), .osc_in(osc_r), .osc_en(en_b),
        .irq(irq_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Oscillator generator: per-channel half period in clocks, 0 = hold
    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (half[i] != 0) begin
                ocnt[i] = ocnt[i] + 1;
                if (ocnt[i] >= half[i]) begin
                    ocnt[i] = 0;
                    osc_r[i] = ~osc_r[i];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: dut=0x%08h expected=0x%08h at cycle %0d", nm, act, exp, cyc_cnt);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: dut=%0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] idx, input int unsigned maxv,
                                           input logic [NCH-1:0] ovf);
        logic [31:0] r;
        r = '0;
        if (idx == 4'd0) begin
            r[NCH-1:0] = m_en;
            r[17] = m_cont;
            r[18] = m_irqen;
        end else if (idx == 4'd1) begin
            r = m_gate;
        end else if (idx == 4'd2) begin
            r[0] = m_busy;
            r[1] = m_done;
            r[8 +: NCH] = ovf;
        end else if (int'(idx) >= 4 && int'(idx) < 4 + NCH) begin
            r = (m_cnt[int'(idx) - 4] > maxv) ? maxv : m_cnt[int'(idx) - 4];
        end
        return r;
    endfunction

    // Behavioural model: one measurement is "gate cycles remaining" plus a latch step
    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_ack = 0; m_busy = 0; m_done = 0; m_cont = 0; m_irqen = 0;
            m_gate = '0; m_en = '0; m_ovf_a = '0; m_ovf_b = '0; m_rem = 0;
            m_h1 = '0; m_h2 = '0; m_h3 = '0;
            for (int i = 0; i < NCH; i++) begin
                m_live[i] = 0;
                m_cnt[i]  = 0;
            end
        end else begin
            t_idx = adr[5:2];
            t_acc = cyc & stb & ~m_ack;
            t_wr  = t_acc & we;
            if (t_acc) begin
                m_dat_a = m_read(t_idx, MAX_A, m_ovf_a);
                m_dat_b = m_read(t_idx, MAX_B, m_ovf_b);
            end
            t_pulse = m_h2 & ~m_h3;
            m_h3 = m_h2; m_h2 = m_h1; m_h1 = osc_r;
            t_start = t_wr && (t_idx == 4'd0) && dat[16];
            t_abort = t_wr && (t_idx == 4'd2) && dat[16];
            t_latch = 1'b0;
            t_set_a = '0;
            t_set_b = '0;
            if (!m_busy) begin
                if (t_start && m_gate != 0) begin
                    m_busy = 1; m_rem = m_gate;
                    for (int i = 0; i < NCH; i++) m_live[i] = 0;
                end
            end else if (t_abort) begin
                m_busy = 0;
            end else if (m_rem > 0) begin
                for (int i = 0; i < NCH; i++)
                    if (t_pulse[i] && m_en[i]) m_live[i] = m_live[i] + 1;
                m_rem = m_rem - 1;
            end else begin
                t_latch = 1'b1;
                for (int i = 0; i < NCH; i++) begin
                    m_cnt[i] = m_live[i];
                    t_set_a[i] = (m_live[i] > MAX_A);
                    t_set_b[i] = (m_live[i] > MAX_B);
                end
                if (m_cont) begin
                    m_rem = m_gate;
                    for (int i = 0; i < NCH; i++) m_live[i] = 0;
                end else begin
                    m_busy = 0;
                end
            end
            if (t_wr) begin
                if (t_idx == 4'd0) begin
                    m_en = dat[NCH-1:0]; m_cont = dat[17]; m_irqen = dat[18];
                end else if (t_idx == 4'd1) begin
                    m_gate = dat & 32'h00FF_FFFF;
                end else if (t_idx == 4'd2) begin
                    if (dat[1]) m_done = 0;
                    m_ovf_a = m_ovf_a & ~dat[8 +: NCH];
                    m_ovf_b = m_ovf_b & ~dat[8 +: NCH];
                end
            end
            if (t_latch) begin
                m_done  = 1;
                m_ovf_a = m_ovf_a | t_set_a;
                m_ovf_b = m_ovf_b | t_set_b;
            end
            m_ack = t_acc;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("ack_a", 32'(ack_a), 32'(m_ack));
            chk("ack_b", 32'(ack_b), 32'(m_ack));
            chk("osc_en_a", 32'(en_a), 32'(m_en));
            chk("osc_en_b", 32'(en_b), 32'(m_en));
            chk("irq_a", 32'(irq_a), 32'(m_done & m_irqen));
            chk("irq_b", 32'(irq_b), 32'(m_done & m_irqen));
            if (m_ack) begin
                chk("rdata_a", dat_a, m_dat_a);
                chk("rdata_b", dat_b, m_dat_b);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] ra, output logic [31:0] rb);
        bit got;
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = 4'($urandom);
        got = 0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge clk);
            if (ack_a) got = 1;
        end
        ra = dat_a; rb = dat_b;
        cyc = 0; stb = 0; we = 0;
        if (!got) chk("ack_timeout", 32'(0), 32'(1));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ra, rb;
        wb_xfer(1'b1, a, d, ra, rb);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] ra, output logic [31:0] rb);
        wb_xfer(1'b0, a, 32'h0, ra, rb);
    endtask

    task automatic wait_done(output logic [31:0] st);
        logic [31:0] sb;
        st = '0;
        for (int k = 0; k < 300; k++) begin
            rd(32'h8, st, sb);
            if (st[1]) return;
        end
        chk("done_timeout", st, 32'h2);
    endtask

    task automatic wait_irq(input int maxc, output int t);
        t = -1;
        for (int k = 0; k < maxc; k++) begin
            @(negedge clk);
            if (irq_a) begin
                t = cyc_cnt;
                return;
            end
        end
        chk("irq_timeout", 32'(0), 32'(1));
    endtask

    logic [31:0] ra, rb, st, prev_a;
    logic [3:0]  pat;
    int          t0, t1, t2;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; cyc = 0; stb = 0; we = 0; sel = '0; adr = '0; dat = '0;
        for (int i = 0; i < NCH; i++) begin half[i] = 0; ocnt[i] = 0; end
        idle(3);
        rst = 0;
        idle(1);
        rd(32'h8, ra, rb);
        chk("reset_status", ra, 32'h0);
        chk("reset_osc_en", 32'(en_a), 32'h0);

        // Scenario 1: period-10 oscillator on channel 0, 100-cycle gate
        half[0] = 5;
        wr(32'h0, 32'h1);
        wr(32'h4, 32'd100);
        wr(32'h0, 32'h10001);
        wait_done(st);
        chk("s1_busy", 32'(st[0]), 32'h0);
        rd(32'h10, ra, rb);
        chk_rng("s1_count0_a", int'(ra), 9, 10);
        chk_rng("s1_count0_b", int'(rb), 9, 10);
        for (int i = 1; i < NCH; i++) begin
            rd(32'h10 + 32'(4 * i), ra, rb);
            chk("s1_countN", ra, 32'h0);
        end

        // Scenario 2: continuous mode with interrupt
        wr(32'h8, 32'h2);
        wr(32'h4, 32'd50);
        wr(32'h0, 32'h70001);
        wait_irq(200, t1);
        rd(32'h8, ra, rb);
        chk("s2_status", ra & 32'h3, 32'h3);
        wr(32'h8, 32'h2);
        chk("s2_irq_clr", 32'(irq_a), 32'h0);
        wait_irq(200, t2);
        chk("s2_period", 32'(t2 - t1), 32'd51);
        idle(5);
        chk("s2_irq_hold", 32'(irq_a), 32'h1);
        wr(32'h8, 32'h2);
        chk("s2_irq_clr2", 32'(irq_a), 32'h0);
        wr(32'h0, 32'h1);
        for (int k = 0; k < 100; k++) begin
            rd(32'h8, st, rb);
            if (!st[0]) break;
        end
        chk("s2_stopped", 32'(st[0]), 32'h0);

        // Scenario 3: period-4 oscillator saturates the 4-bit instance
        half[0] = 2;
        wr(32'h8, 32'h0F02);
        wr(32'h4, 32'd100);
        wr(32'h0, 32'h10001);
        wait_done(st);
        rd(32'h10, ra, rb);
        chk("s3_count0_b", rb, 32'd15);
        chk_rng("s3_count0_a", int'(ra), 24, 26);
        rd(32'h8, ra, rb);
        chk("s3_ovf_b", 32'(rb[8]), 32'h1);
        chk("s3_ovf_a", 32'(ra[8]), 32'h0);
        wr(32'h8, 32'h100);
        rd(32'h8, ra, rb);
        chk("s3_ovf_clr", 32'(rb[8]), 32'h0);

        // Scenario 4: abort mid-gate keeps results; zero gate never starts
        half[0] = 5;
        rd(32'h10, prev_a, rb);
        wr(32'h8, 32'h2);
        wr(32'h0, 32'h10001);
        idle(18);
        wr(32'h8, 32'h10000);
        rd(32'h8, ra, rb);
        chk("s4_abort_status", ra & 32'h3, 32'h0);
        rd(32'h10, ra, rb);
        chk("s4_count_kept_a", ra, prev_a);
        chk("s4_count_kept_b", rb, 32'd15);
        wr(32'h4, 32'd0);
        wr(32'h0, 32'h10001);
        rd(32'h8, ra, rb);
        chk("s4_gate0_busy", 32'(ra[0]), 32'h0);

        // Scenario 5: reset mid-gate, then held strobe
        wr(32'h4, 32'd100);
        wr(32'h0, 32'h1000F);
        idle(28);
        rst = 1;
        idle(2);
        rst = 0;
        chk("s5_osc_en", 32'(en_a), 32'h0);
        for (int i = 0; i < 3 + NCH; i++) begin
            rd((i < 3) ? 32'(4 * i) : 32'h10 + 32'(4 * (i - 3)), ra, rb);
            chk("s5_reg_zero_a", ra, 32'h0);
            chk("s5_reg_zero_b", rb, 32'h0);
        end
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 32'h4;
        for (int k = 0; k < 4; k++) begin
            pat[3 - k] = ack_a;
            @(negedge clk);
        end
        cyc = 0; stb = 0;
        chk("s5_ack_pattern", 32'(pat), 32'(4'b0101));

        // Scenario 6: unmapped reads, start while busy
        rd(32'h3C, ra, rb);
        chk("s6_rd_3c", ra, 32'h0);
        rd(32'h10 + 32'(4 * NCH), ra, rb);
        chk("s6_rd_past", ra, 32'h0);
        wr(32'h4, 32'd100);
        wr(32'h0, 32'h50001);
        t0 = cyc_cnt;
        idle(40);
        wr(32'h0, 32'h50001);
        wait_irq(300, t1);
        chk("s6_no_restart", 32'(t1 - t0), 32'd101);
        wr(32'h8, 32'h0F02);
        wr(32'h0, 32'h0);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0, 1: wr(32'h4, 32'($urandom_range(0, 40)));
                2, 3: wr(32'h0, ($urandom & 32'h0006_000F) | (32'($urandom_range(0, 1)) << 16));
                4: wr(32'h8, ($urandom & 32'h0F02) |
                          (($urandom_range(0, 5) == 0) ? 32'h10000 : 32'h0));
                5, 6, 7: rd(32'($urandom_range(0, 15)) << 2, ra, rb);
                8: idle($urandom_range(0, 30));
                default: for (int i = 0; i < NCH; i++) half[i] = $urandom_range(0, 6);
            endcase
            if ($urandom_range(0, 99) == 0) begin
                @(negedge clk);
                rst = 1;
                @(negedge clk);
                rst = 0;
            end
        end
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/osc_freq_counter.md
OSC_FREQ_COUNTER -- requirements
Module: osc_freq_counter

Interface
REQ-001 The block SHALL have parameter NCH, default 4, giving the number of oscillator channels (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 24, giving the per-channel edge counter width (<=32).
REQ-003 The block SHALL have parameter GATE_W, default 24, giving the gate-length register width (<=32).
REQ-004 The block SHALL have port wb_clk_i, input, 1 bit: the single clock for all logic.
REQ-005 The block SHALL have port wb_rst_i, input, 1 bit: the reset, which is synchronous and active-high.
REQ-006 The block SHALL have port wbs_cyc_i, input, 1 bit: Wishbone cycle.
REQ-007 The block SHALL have port wbs_stb_i, input, 1 bit: Wishbone strobe.
REQ-008 The block SHALL have port wbs_we_i, input, 1 bit: Wishbone write enable.
REQ-009 The block SHALL have port wbs_sel_i, input, 4 bits: byte selects, ignored; all writes are full-word.
REQ-010 The block SHALL have port wbs_adr_i, input, 32 bits: address; only bits [5:2] are decoded.
REQ-011 The block SHALL have port wbs_dat_i, input, 32 bits: write data.
REQ-012 The block SHALL have port wbs_ack_o, output, 1 bit: Wishbone acknowledge.
REQ-013 The block SHALL have port wbs_dat_o, output, 32 bits: registered read data.
REQ-014 The block SHALL have port osc_in, input, NCH bits: asynchronous ring-oscillator outputs.
REQ-015 The block SHALL have port osc_en, output, NCH bits: oscillator enables, driven by CTRL[NCH-1:0].
REQ-016 The block SHALL have port irq, output, 1 bit: level interrupt, equal to STATUS.done AND CTRL.irq_en.

Function
REQ-017 The register map SHALL be as follows (word addresses).
- 0x00 CTRL, RW: [7:0] osc_en (bits >=NCH read 0); [16] start (write-1 pulse, reads 0); [17] cont; [18] irq_en.
- 0x04 GATE, RW: [GATE_W-1:0] gate length in clocks.
- 0x08 STATUS: [0] busy (RO); [1] done (W1C); [15:8] ovf per channel (W1C); [16] abort (write-1 pulse, reads 0).
- 0x10+4*i COUNT[i], RO: zero-extended latched count for i<NCH.
- All other addresses read 0 and ignore writes.
REQ-018 wbs_ack_o SHALL pulse exactly one cycle, on the cycle after wbs_cyc_i&wbs_stb_i is seen with ack low, and SHALL never be asserted on two consecutive cycles.
- Read data SHALL be valid in the ack cycle.
- The write SHALL take effect at the ack edge.
REQ-019 Each osc_in bit SHALL pass through a 2-flop synchroniser plus a third flop, giving a one-cycle rising-edge pulse per channel.
REQ-020 The FSM SHALL have states IDLE, GATE and LATCH.
- IDLE->GATE on a start write with GATE!=0: load gate_cnt=GATE, clear all live counters. Start with GATE=0 SHALL be ignored.
- In GATE, gate_cnt decrements each cycle; GATE->LATCH in the cycle gate_cnt==1.
- LATCH lasts one cycle: copy live counters to COUNT[i], set done, OR overflow flags into ovf; then go to GATE if cont=1 (reload from GATE, clear live counters), else IDLE.
REQ-021 A live counter SHALL increment on an edge pulse only in cycles where state==GATE and osc_en[i]=1.
REQ-022 Live counters SHALL saturate at 2^CNT_W-1; an increment attempted at saturation SHALL set that channel's overflow flag.
REQ-023 busy SHALL be 1 in GATE and LATCH.
REQ-024 A start write while busy SHALL be ignored.
REQ-025 Clearing cont during GATE SHALL end the run after the current LATCH.
REQ-026 An abort write SHALL force IDLE on the next cycle with no latch.
- COUNT, done and ovf are unchanged by an abort.
- Abort has priority over start in the same write.
REQ-027 On a simultaneous W1C of done and a LATCH setting done in the same cycle, the set SHALL win.
REQ-028 The latched count SHALL be exactly the number of edge pulses in the GATE cycles, so an N-cycle gate measures f_osc ≈ COUNT*f_clk/N.
- Edges within 3 cycles of gate end may fall outside the window; this is accepted.

Reset
REQ-029 While wb_rst_i=1 at a clock edge, the block SHALL apply the following state:
- State=IDLE; CTRL, GATE, STATUS, all COUNT and live counters = 0.
- Synchroniser flops = 0.
- wbs_ack_o=0, wbs_dat_o=0, osc_en=0, irq=0.
REQ-030 Reset asserted mid-gate or mid-bus-cycle SHALL abandon the operation with no ack and no latch.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- NCH=4: write CTRL=0x1, GATE=100, CTRL=0x10001; osc_in[0] toggles with period 10 clk -> after done, COUNT0 in 9..10, COUNT1..3=0, busy=0.
- CTRL=0x70001, GATE=50: done set after the first LATCH; a second latch occurs 51 cycles later; irq=1 until STATUS written 0x2.
- CNT_W=4, GATE=100, osc_in[0] period 4 clk -> COUNT0=15, STATUS.ovf[0]=1; writing 0x100 clears it.
- Abort at gate cycle 20 -> busy=0 next cycle; COUNT keeps its previous value; done not set. Start with GATE=0 -> busy stays 0.
- Reset asserted at gate cycle 30 -> all registers read 0 and osc_en=0. Back-to-back stb held high -> ack pattern 0,1,0,1.
- A read from 0x3C or 0x10+4*NCH returns 0. A start written while busy does not restart gate_cnt.
